l1_timer_device: RTL
====================

// Module: l1_timer_device
// PURPOSE
//  Memory-mapped machine timer acting as a responder on one device port of the L1 variable-latency interconnect.
//  Accepts valid/ready requests from the interconnect and returns a one-entry-buffered response tagged with the initiator index.
//  Drives the core's timer interrupt when enabled and mtime >= mtimecmp.
// PARAMETERS
//  DataWidth     32  bus data width; only 32 is supported
//  AddrWidth     12  device-local byte address width (4 KiB window)
//  NbrHostsLog2  1   width of the initiator index carried with each request
// PORTS
//  clk_i            in   1             system clock
//  rst_i            in   1             synchronous reset, active-high
//  req_valid_i      in   1             request valid from interconnect
//  req_ready_o      out  1             device can accept a request this cycle
//  req_ini_addr_i   in   NbrHostsLog2  initiator index of the request
//  req_tgt_addr_i   in   AddrWidth     byte address inside the window
//  req_wen_i        in   1             1 = write, 0 = read
//  req_wdata_i      in   DataWidth     write data
//  req_be_i         in   DataWidth/8   byte enables (writes only)
//  resp_valid_o     out  1             response valid
//  resp_ready_i     in   1             interconnect accepts the response
//  resp_ini_addr_o  out  NbrHostsLog2  initiator index echoed with the response
//  resp_rdata_o     out  DataWidth     read data (0 for writes)
//  timer_irq_o      out  1             level timer interrupt to the core
// BEHAVIOUR
//  Register map (word aligned; addr[1:0] ignored; unmapped reads return 0, unmapped writes are dropped; both still respond):
//   0x000 MTIME_LO   0x004 MTIME_HI   0x008 MTIMECMP_LO   0x00C MTIMECMP_HI
//   0x010 CTRL: bit0 EN (count enable and irq enable); other bits read 0
//   0x014 PRESCALE (optional; see CONFIGURATION)
//  Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, PRESCALE = 0.
//  Reset outputs: resp_valid_o = 0, resp_rdata_o = 0, resp_ini_addr_o = 0, timer_irq_o = 0.
//  Handshake:
//   - A request is accepted on the cycle req_valid_i && req_ready_o.
//   - req_ready_o = !resp_valid_o || resp_ready_i (combinational). This gives a single-entry response buffer.
//   - The response is registered: resp_valid_o rises the cycle after acceptance. Latency is 1 cycle with no back-pressure.
//   - resp_valid_o, resp_rdata_o and resp_ini_addr_o stay stable until resp_ready_i is seen high.
//   - If a response is consumed and a new request is accepted in the same cycle, the new response loads and resp_valid_o stays 1 (back-to-back throughput of 1 per cycle).
//  Read data is sampled at acceptance. A read of MTIME_LO returns the pre-increment value of that cycle.
//  Writes apply byte-wise per req_be_i. A write with be = 0 responds but changes nothing.
//  Counter:
//   - When EN = 1 and a tick occurs, mtime <= mtime + 1 (64-bit, wraps FFFF..FF -> 0).
//   - A write to MTIME_LO/HI in the same cycle as a tick takes priority; no increment that cycle.
//   - Writing one half leaves the other half unchanged and performs no carry.
//  Interrupt:
//   - timer_irq_o is registered: next cycle = EN && (mtime >= mtimecmp), using an unsigned 64-bit compare on post-update values.
//   - It is a level signal; it clears one cycle after mtimecmp is written above mtime or EN is cleared.
//  Reset mid-transaction: the pending response is dropped and resp_valid_o is 0 on the next cycle. Any request presented in the reset cycle is ignored.
// CONFIGURATION
//  TIMER_PRESCALER_EN defined:
//   - PRESCALE[15:0] is read/write; bits [31:16] read 0.
//   - A 16-bit prescale counter counts up while EN = 1.
//   - A tick is generated and the prescale counter clears when it equals PRESCALE, so the period is PRESCALE+1 cycles.
//   - Writing PRESCALE or clearing EN clears the prescale counter.
//  TIMER_PRESCALER_EN undefined:
//   - A tick occurs every cycle while EN = 1.
//   - PRESCALE reads 0 and writes are dropped; no prescale logic is instantiated.
// TESTING
//  1. Reset, then read 0x010, 0x000 and 0x00C -> resp 0x0, 0x0, 0xFFFF_FFFF, each one cycle after acceptance, with resp_ini_addr_o = req_ini_addr_i.
//  2. Write CTRL = 1, wait 10 cycles, read MTIME_LO -> value equals the number of cycles between the EN write acceptance and the read acceptance (prescaler off or PRESCALE = 0).
//  3. Write MTIMECMP_HI = 0, then MTIMECMP_LO = 20, with EN = 1 -> timer_irq_o rises one cycle after mtime reaches 20. Then write MTIMECMP_LO = 0xFFFF_FFFF -> irq falls one cycle later.
//  4. Hold resp_ready_i = 0 and issue a read then a second request -> req_ready_o = 0 while the first response is held stable. Then release resp_ready_i -> the second request is accepted in the same cycle and both responses arrive in order.
//  5. Write MTIME_LO = 0xFFFF_FFFE and MTIME_HI = 0xFFFF_FFFF, with EN = 1 -> after 2 ticks, mtime wraps to 0 and irq is asserted for the default mtimecmp before the wrap.
//  6. TIMER_PRESCALER_EN: PRESCALE = 3, EN = 1 -> MTIME_LO increments every 4 cycles. Byte write be = 4'b0010 with data 0x0000_AB00 to MTIMECMP_LO -> only bits [15:8] change.

Source files
------------

// File: rtl/l1_timer_device.sv
// Memory-mapped machine timer (mtime/mtimecmp/CTRL) responding on one L1 interconnect device port.
// Latency: response registered, valid one cycle after request acceptance.
// Backpressure: single-entry response buffer; req_ready_o = !resp_valid_o || resp_ready_i.
// Optional prescaler register at 0x014 enabled by defining TIMER_PRESCALER_EN.
module l1_timer_device #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 12,
  parameter int NbrHostsLog2 = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [NbrHostsLog2-1:0] req_ini_addr_i,
  input  logic [AddrWidth-1:0]    req_tgt_addr_i,
  input  logic                    req_wen_i,
  input  logic [DataWidth-1:0]    req_wdata_i,
  input  logic [DataWidth/8-1:0]  req_be_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [NbrHostsLog2-1:0] resp_ini_addr_o,
  output logic [DataWidth-1:0]    resp_rdata_o,
  output logic                    timer_irq_o
);

  localparam int WW = AddrWidth - 2;
  localparam logic [WW-1:0] W_MTIME_LO = WW'(0);
  localparam logic [WW-1:0] W_MTIME_HI = WW'(1);
  localparam logic [WW-1:0] W_CMP_LO   = WW'(2);
  localparam logic [WW-1:0] W_CMP_HI   = WW'(3);
  localparam logic [WW-1:0] W_CTRL     = WW'(4);
  localparam logic [WW-1:0] W_PSC      = WW'(5);

  // Byte-lane merge of write data into an existing 32-bit register value.
  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    end
    return r;
  endfunction

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        irq_q, irq_d;
  logic        resp_valid_q;
  logic [NbrHostsLog2-1:0] resp_ini_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] rd_mux;
  logic        tick;

  logic [WW-1:0] word;
  logic          accept, wr;
  logic          wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl, wr_psc;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_tgt_addr_i[1:0];

  assign word        = req_tgt_addr_i[AddrWidth-1:2];
  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr          = accept && req_wen_i;
  assign wr_mlo      = wr && (word == W_MTIME_LO);
  assign wr_mhi      = wr && (word == W_MTIME_HI);
  assign wr_clo      = wr && (word == W_CMP_LO);
  assign wr_chi      = wr && (word == W_CMP_HI);
  assign wr_ctrl     = wr && (word == W_CTRL);
  assign wr_psc      = wr && (word == W_PSC);

  // Enable bit only lives in byte lane 0.
  assign en_d = (wr_ctrl && req_be_i[0]) ? req_wdata_i[0] : en_q;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d, pscnt_q, pscnt_d;
  logic [31:0] psc_merged;

  assign tick       = en_q && (pscnt_q == prescale_q);
  assign psc_merged = bmerge({16'h0, prescale_q}, req_wdata_i, req_be_i);

  // Prescale register update and free-running divider; cleared on reprogram or disable.
  always_comb begin
    prescale_d = prescale_q;
    if (wr_psc) prescale_d = psc_merged[15:0];
    pscnt_d = pscnt_q;
    if (wr_psc || !en_d)  pscnt_d = 16'h0;
    else if (tick)        pscnt_d = 16'h0;
    else if (en_q)        pscnt_d = pscnt_q + 16'h1;
  end

  // Prescaler state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_q <= 16'h0;
      pscnt_q    <= 16'h0;
    end else begin
      prescale_q <= prescale_d;
      pscnt_q    <= pscnt_d;
    end
  end
`else
  logic unused_psc;
  assign unused_psc = wr_psc;
  assign tick       = en_q;
`endif

  // Next-state for the counter and compare registers; a bus write to mtime beats the tick.
  always_comb begin
    mtime_d = mtime_q;
    if ((wr_mlo || wr_mhi) && (|req_be_i)) begin
      if (wr_mlo) mtime_d[31:0]  = bmerge(mtime_q[31:0],  req_wdata_i, req_be_i);
      if (wr_mhi) mtime_d[63:32] = bmerge(mtime_q[63:32], req_wdata_i, req_be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    mtimecmp_d = mtimecmp_q;
    if (wr_clo) mtimecmp_d[31:0]  = bmerge(mtimecmp_q[31:0],  req_wdata_i, req_be_i);
    if (wr_chi) mtimecmp_d[63:32] = bmerge(mtimecmp_q[63:32], req_wdata_i, req_be_i);
    irq_d = en_d && (mtime_d >= mtimecmp_d);
  end

  // Read mux on current (pre-update) register values.
  always_comb begin
    rd_mux = 32'h0;
    case (word)
      W_MTIME_LO: rd_mux = mtime_q[31:0];
      W_MTIME_HI: rd_mux = mtime_q[63:32];
      W_CMP_LO:   rd_mux = mtimecmp_q[31:0];
      W_CMP_HI:   rd_mux = mtimecmp_q[63:32];
      W_CTRL:     rd_mux = {31'h0, en_q};
`ifdef TIMER_PRESCALER_EN
      W_PSC:      rd_mux = {16'h0, prescale_q};
`endif
      default:    rd_mux = 32'h0;
    endcase
  end

  // Timer state, interrupt and single-entry response buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q      <= 64'h0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q         <= 1'b0;
      irq_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ini_q   <= '0;
      resp_rdata_q <= 32'h0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      irq_q      <= irq_d;
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_ini_q   <= req_ini_addr_i;
        resp_rdata_q <= req_wen_i ? 32'h0 : rd_mux;
      end else if (resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid_o    = resp_valid_q;
  assign resp_ini_addr_o = resp_ini_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign timer_irq_o     = irq_q;

endmodule
